// File: rtl/rsrx_02a.sv
// rsrx_02a -- oversampling asynchronous serial receiver with a small
// first-word-fall-through FIFO carrying per-entry error flags.
//
// The line is double-flopped. A runtime prescaler produces oversample ticks.
// A tick-driven FSM then takes a 3-sample majority vote at the centre of each
// bit and pushes {parityErr, frameErr, data} into the FIFO.
//
// Optional feature macro: RSRX_PARITY_EN
//   Defined:   one parity bit follows the data bits. PARITY_ODD selects odd
//              or even parity, and a mismatch is reported on rxError[1].
//   Undefined: no parity bit. rxError[1] is always 0.
//
// Ports:
//   clk            single clock for the whole block
//   reset_n        synchronous active-low reset
//   rxSerialData   asynchronous serial line, idle high
//   baudDiv        oversample tick every baudDiv+1 clk cycles
//   rxParallelData FIFO head word, 0 when empty
//   rxError        head-entry flags {parityErr, frameErr}, 0 when empty
//   rxTrigger      pop the head entry (ignored when empty)
//   rxErrClear     clears sticky overrun
//   rxStatus       {overrun, fifoFull, dataExist, busy}
module rsrx_02a #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rxSerialData,
  input  logic [DIV_WIDTH-1:0] baudDiv,
  output logic [DATA_BITS-1:0] rxParallelData,
  output logic [1:0]           rxError,
  input  logic                 rxTrigger,
  input  logic                 rxErrClear,
  output logic [3:0]           rxStatus
);

  localparam int SCW  = $clog2(OVERSAMPLE);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int ENTW = DATA_BITS + 2;
  localparam int MID  = OVERSAMPLE / 2;

  localparam logic [SCW-1:0]  VOTE_A      = SCW'(MID - 1);
  localparam logic [SCW-1:0]  VOTE_B      = SCW'(MID);
  localparam logic [SCW-1:0]  DECIDE      = SCW'(MID + 1);
  localparam logic [SCW-1:0]  LAST_SAMPLE = SCW'(OVERSAMPLE - 1);
  localparam logic [3:0]      LAST_DATA   = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP   = 4'(STOP_BITS - 1);
  localparam logic [CNTW-1:0] DEPTH       = CNTW'(FIFO_DEPTH);

`ifdef RSRX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  // Parity bit the transmitter should have sent for this data word.
  function automatic logic expectedParity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PAR_ODD;
  endfunction

  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4
  } state_t;
`endif

  logic                 sync1, lineS;
  logic [DIV_WIDTH-1:0] prescCnt;
  logic                 tick;
  state_t               state;
  logic [SCW-1:0]       sampleCnt;
  logic [3:0]           bitCnt;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 vote0, vote1, majS;
  logic                 decideS, bitEndS, pushS;
  logic                 frameErr, parityErr, busy;
  logic [ENTW-1:0]      pushEntry, headEntry;
  logic [ENTW-1:0]      mem [FIFO_DEPTH];
  logic [PTRW-1:0]      wrPtr, rdPtr;
  logic [CNTW-1:0]      count;
  logic                 overrun, fullS, emptyS, popS, wrEnS;

  // Two-flop synchroniser; idle-high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      lineS <= 1'b1;
    end else begin
      sync1 <= rxSerialData;
      lineS <= sync1;
    end
  end

  // Free-running prescaler; a new baudDiv is only picked up on reload.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prescCnt <= baudDiv;
    end else if (prescCnt == '0) begin
      prescCnt <= baudDiv;
    end else begin
      prescCnt <= prescCnt - DIV_WIDTH'(1);
    end
  end

  assign tick    = (prescCnt == '0);
  assign majS    = (vote0 & vote1) | (vote0 & lineS) | (vote1 & lineS);
  assign decideS = (sampleCnt == DECIDE);
  assign bitEndS = (sampleCnt == LAST_SAMPLE);
  // The last stop bit's vote goes straight into the entry so that the push
  // can happen on the decision tick itself.
  assign pushS   = tick && (state == STOP) && decideS && (bitCnt == LAST_STOP);
  assign pushEntry = {parityErr, frameErr | ~majS, shiftReg};

`ifndef RSRX_PARITY_EN
  assign parityErr = 1'b0;
`endif

  // Receive FSM: advances on oversample ticks only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      sampleCnt <= '0;
      bitCnt    <= 4'd0;
      shiftReg  <= '0;
      vote0     <= 1'b1;
      vote1     <= 1'b1;
      frameErr  <= 1'b0;
`ifdef RSRX_PARITY_EN
      parityErr <= 1'b0;
`endif
      busy      <= 1'b0;
    end else if (tick) begin
      if (state != IDLE) begin
        sampleCnt <= bitEndS ? '0 : sampleCnt + SCW'(1);
        if (sampleCnt == VOTE_A) vote0 <= lineS;
        if (sampleCnt == VOTE_B) vote1 <= lineS;
      end
      case (state)
        IDLE: begin
          // The tick that sees the low line counts as sample 0 of the start bit.
          if (!lineS) begin
            state     <= START;
            sampleCnt <= SCW'(1);
            bitCnt    <= 4'd0;
            busy      <= 1'b1;
            frameErr  <= 1'b0;
`ifdef RSRX_PARITY_EN
            parityErr <= 1'b0;
`endif
          end
        end
        START: begin
          if (decideS && majS) begin
            state     <= IDLE;
            sampleCnt <= '0;
            busy      <= 1'b0;
          end else if (bitEndS) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (decideS) shiftReg <= {majS, shiftReg[DATA_BITS-1:1]};
          if (bitEndS) begin
            if (bitCnt == LAST_DATA) begin
              bitCnt <= 4'd0;
`ifdef RSRX_PARITY_EN
              state  <= PARITY;
`else
              state  <= STOP;
`endif
            end else begin
              bitCnt <= bitCnt + 4'd1;
            end
          end
        end
`ifdef RSRX_PARITY_EN
        PARITY: begin
          if (decideS) parityErr <= (majS != expectedParity(shiftReg));
          if (bitEndS) state <= STOP;
        end
`endif
        STOP: begin
          if (decideS && !majS) frameErr <= 1'b1;
          if (pushS) begin
            state     <= IDLE;
            sampleCnt <= '0;
            busy      <= 1'b0;
          end else if (bitEndS) begin
            bitCnt <= bitCnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign emptyS = (count == '0);
  assign fullS  = (count == DEPTH);
  assign popS   = rxTrigger && !emptyS;
  // A pop on the same edge frees the slot, so a push at full is still taken.
  assign wrEnS  = pushS && (!fullS || popS);

  // FIFO storage; no reset needed because reads are masked while empty.
  always_ff @(posedge clk) begin
    if (wrEnS) mem[wrPtr] <= pushEntry;
  end

  // FIFO pointers, occupancy and sticky overrun (set beats clear).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wrEnS) wrPtr <= wrPtr + PTRW'(1);
      if (popS)  rdPtr <= rdPtr + PTRW'(1);
      case ({wrEnS, popS})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      if (pushS && fullS && !popS) begin
        overrun <= 1'b1;
      end else if (rxErrClear) begin
        overrun <= 1'b0;
      end
    end
  end

  // Output decode from registers only; the head reads as zero when empty.
  always_comb begin
    headEntry = mem[rdPtr];
    if (!emptyS) begin
      rxParallelData = headEntry[DATA_BITS-1:0];
      rxError        = headEntry[ENTW-1:DATA_BITS];
    end else begin
      rxParallelData = '0;
      rxError        = 2'b00;
    end
    rxStatus = {overrun, fullS, !emptyS, busy};
  end

endmodule

// File: tb/tb_rsrx_02a.sv
// Directed, table-driven bench for rsrx_02a (default parameters, plus a
// second instance with two stop bits sharing the same serial line).
module tb_rsrx_02a;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       reset2_n = 1'b0;
  logic       line = 1'b1;
  logic [15:0] baudDiv = 16'd0;
  logic       rxTrigger = 1'b0;
  logic       rxErrClear = 1'b0;
  logic       trig2 = 1'b0;
  logic       clear2 = 1'b0;
  logic [7:0] rxData, data2;
  logic [1:0] rxErr, err2;
  logic [3:0] rxStatus, status2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rsrx_02a dut (
    .clk(clk), .reset_n(reset_n), .rxSerialData(line), .baudDiv(baudDiv),
    .rxParallelData(rxData), .rxError(rxErr), .rxTrigger(rxTrigger),
    .rxErrClear(rxErrClear), .rxStatus(rxStatus)
  );

  rsrx_02a #(.STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset2_n), .rxSerialData(line), .baudDiv(baudDiv),
    .rxParallelData(data2), .rxError(err2), .rxTrigger(trig2),
    .rxErrClear(clear2), .rxStatus(status2)
  );

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    logic [7:0] expData;
    logic [1:0] expErr;
  } vec_t;

  vec_t vecs [6];

`ifdef RSRX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame LSB first. popAt > 0 raises rxTrigger for exactly the
  // negedge-to-negedge cycle numbered popAt after the start bit begins.
  task automatic sendFrame(input logic [7:0] data, input logic [1:0] stops, input int nStops,
                           input logic parBit, input int bitClks, input int popAt);
    logic [11:0] bits;
    int n;
    int cyc;
    bits = 12'hFFF;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    n = 9;
`ifdef RSRX_PARITY_EN
    bits[n] = parBit;
    n++;
`endif
    for (int s = 0; s < nStops; s++) begin
      bits[n] = stops[s];
      n++;
    end
    cyc = 0;
    for (int b = 0; b < n; b++) begin
      line = bits[b];
      repeat (bitClks) begin
        @(negedge clk);
        cyc++;
        if (popAt > 0) rxTrigger = (cyc == popAt);
      end
    end
    line = 1'b1;
  endtask

  task automatic pop1();
    rxTrigger = 1'b1;
    @(negedge clk);
    rxTrigger = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 8'h55, 2'b00};
    vecs[1] = '{8'hA3, 1'b0, 8'hA3, 2'b01};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 2'b00};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 2'b00};
    vecs[4] = '{8'h3C, 1'b1, 8'h3C, 2'b00};
    vecs[5] = '{8'h80, 1'b0, 8'h80, 2'b01};

    // Reset state
    waitClk(3);
    check("reset_status", rxStatus, 4'b0000);
    check("reset_data", rxData, 8'h00);
    check("reset_err", rxErr, 2'b00);
    reset_n = 1'b1;
    waitClk(5);

    // Table of single frames, each read and popped
    for (int i = 0; i < 6; i++) begin
      sendFrame(vecs[i].data, {1'b1, vecs[i].stopBit}, 1, ^vecs[i].data, 16, 0);
      waitClk(48);
      check($sformatf("vec%0d_exist", i), rxStatus[1], 1'b1);
      check($sformatf("vec%0d_busy", i), rxStatus[0], 1'b0);
      check($sformatf("vec%0d_data", i), rxData, vecs[i].expData);
      check($sformatf("vec%0d_err", i), rxErr, vecs[i].expErr);
      pop1();
      check($sformatf("vec%0d_popstatus", i), rxStatus, 4'b0000);
      check($sformatf("vec%0d_popdata", i), rxData, 8'h00);
    end

    // Four-tick glitch: false start, no push
    line = 1'b0;
    waitClk(4);
    line = 1'b1;
    waitClk(2);
    check("glitch_busy_high", rxStatus, 4'b0001);
    waitClk(14);
    check("glitch_done", rxStatus, 4'b0000);

    // Five back-to-back frames with no pops: fifth dropped
    for (int i = 1; i <= 5; i++) sendFrame(8'(i), 2'b11, 1, ^(8'(i)), 16, 0);
    waitClk(20);
    check("ovf_status", rxStatus, 4'b1110);
    check("ovf_head", rxData, 8'h01);
    rxErrClear = 1'b1;
    waitClk(1);
    rxErrClear = 1'b0;
    check("ovf_cleared", rxStatus, 4'b0110);
    // Pop on exactly the push edge of the next frame while full
    sendFrame(8'h06, 2'b11, 1, ^(8'h06), 16, 16 * (9 + P) + 11);
    waitClk(20);
    check("pushpop_status", rxStatus, 4'b0110);
    check("pushpop_head", rxData, 8'h02);
    rxTrigger = 1'b1;
    waitClk(2);
    rxTrigger = 1'b0;
    check("multipop_head", rxData, 8'h04);
    pop1();
    check("drain_head", rxData, 8'h06);
    pop1();
    check("drain_empty", rxStatus, 4'b0000);
    pop1();
    check("pop_empty", rxStatus, 4'b0000);

    // Reset mid-DATA with an entry present
    sendFrame(8'h55, 2'b11, 1, ^(8'h55), 16, 0);
    waitClk(20);
    check("pre_reset_exist", rxStatus, 4'b0010);
    line = 1'b0;
    waitClk(16);
    line = 1'b1;
    waitClk(16);
    line = 1'b0;
    waitClk(8);
    check("mid_frame_busy", rxStatus[0], 1'b1);
    reset_n = 1'b0;
    line = 1'b1;
    waitClk(1);
    check("midreset_status", rxStatus, 4'b0000);
    check("midreset_data", rxData, 8'h00);
    check("midreset_err", rxErr, 2'b00);
    reset_n = 1'b1;
    waitClk(60);
    check("after_reset_empty", rxStatus, 4'b0000);
    sendFrame(8'h3C, 2'b11, 1, ^(8'h3C), 16, 0);
    waitClk(40);
    check("after_reset_data", rxData, 8'h3C);
    check("after_reset_err", rxErr, 2'b00);
    pop1();

`ifdef RSRX_PARITY_EN
    // Even parity on 0x07 (three ones): correct bit is 1
    sendFrame(8'h07, 2'b11, 1, 1'b1, 16, 0);
    waitClk(48);
    check("par_ok_err", rxErr, 2'b00);
    check("par_ok_data", rxData, 8'h07);
    pop1();
    sendFrame(8'h07, 2'b11, 1, 1'b0, 16, 0);
    waitClk(48);
    check("par_bad_err", rxErr, 2'b10);
    pop1();
`endif

    // Slower divider: baudDiv=3 -> 64 clk per bit
    baudDiv = 16'd3;
    waitClk(10);
    sendFrame(8'hC5, 2'b11, 1, ^(8'hC5), 64, 0);
    waitClk(200);
    check("div3_data", rxData, 8'hC5);
    check("div3_err", rxErr, 2'b00);
    pop1();
    check("div3_popped", rxStatus, 4'b0000);
`ifdef RSRX_PARITY_EN
    sendFrame(8'h07, 2'b11, 1, 1'b1, 64, 0);
    waitClk(200);
    check("div3_par_ok", rxErr, 2'b00);
    pop1();
    sendFrame(8'h07, 2'b11, 1, 1'b0, 64, 0);
    waitClk(200);
    check("div3_par_bad", rxErr, 2'b10);
    pop1();
`endif
    baudDiv = 16'd0;
    waitClk(200);

    // Two-stop-bit instance: second stop bit low is a framing error
    reset2_n = 1'b1;
    waitClk(5);
    check("stop2_reset", status2, 4'b0000);
    sendFrame(8'hA3, 2'b01, 2, ^(8'hA3), 16, 0);
    waitClk(48);
    check("stop2_bad_data", data2, 8'hA3);
    check("stop2_bad_err", err2, 2'b01);
    trig2 = 1'b1;
    waitClk(1);
    trig2 = 1'b0;
    check("stop2_popped", status2, 4'b0000);
    sendFrame(8'h5A, 2'b11, 2, ^(8'h5A), 16, 0);
    waitClk(48);
    check("stop2_ok_data", data2, 8'h5A);
    check("stop2_ok_err", err2, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
